adc_dac_stream_bridge: RTL and testbench
========================================

Name: adc_dac_stream_bridge

Overview:
- Parametrised successor to the fixed 8-bit ADC/DAC glue logic. Generates the converter clocks from global_clk, captures ADC samples into a FIFO and streams them to the FFT/processing side through a valid/ready interface.
- Drives the DAC from one of four selectable sources: upstream stream, loopback, inverted loopback or midscale.
- Sits between the converter pins and fft_controller in top.

Parameters:
- DATA_W, 8, converter sample width in bits (≥2).
- CLK_DIV, 4, global_clk cycles per converter sample; even, ≥2.
- FIFO_DEPTH, 8, capture FIFO entries; power of two, ≥2.

Ports:
- global_clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- adin_data  in  DATA_W  ADC parallel data.
- adclk  out  1  ADC sample clock.
- daclk  out  1  DAC sample clock; identical to adclk.
- daout_data  out  DATA_W  DAC parallel data, registered.
- mode  in  2  DAC source select: 00 stream, 01 loopback, 10 inverted loopback, 11 midscale.
- smp_data  out  DATA_W  captured sample at the FIFO head.
- smp_valid  out  1  FIFO not empty.
- smp_ready  in  1  consumer accepts smp_data.
- dac_data  in  DATA_W  upstream DAC sample.
- dac_valid  in  1  dac_data is valid.
- dac_ready  out  1  bridge consumes dac_data this cycle.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- ovf_cnt  out  8  dropped ADC samples, saturating.
- udf_cnt  out  8  DAC ticks with no upstream data in mode 00, saturating.

Behaviour:
- Reset: div_cnt=0, adclk=daclk=1, daout_data=midscale (1<<(DATA_W-1)), FIFO empty, smp_valid=0, fifo_level=0, ovf_cnt=udf_cnt=0, dac_ready=0. Reset mid-operation discards FIFO contents and counters immediately.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. adclk is registered, high while div_cnt < CLK_DIV/2.
- tick: asserted for the single cycle where div_cnt==CLK_DIV-1, i.e. the cycle before adclk rises.
- Capture: on tick, adin_data is pushed into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the sample is dropped and ovf_cnt increments, saturating at 255.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted with no overflow.
- FIFO: first-word-fall-through. Pop when smp_valid && smp_ready.
  - A pushed sample appears on smp_data/smp_valid one cycle after tick when the FIFO was empty.
  - fifo_level updates the cycle after each push/pop; a simultaneous push and pop leaves it unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- DAC path: daout_data is updated only on tick, so it is stable before the next daclk rising edge. mode is sampled at tick, so a mode change takes effect at the next tick.
  - 00: dac_ready=tick. If dac_valid is high at tick, daout_data<=dac_data. Otherwise daout_data holds and udf_cnt increments, saturating at 255.
  - 01: daout_data<=adin_data.
  - 10: daout_data<=~adin_data.
  - 11: daout_data<=midscale.
- dac_ready is 0 in all cycles except a tick in mode 00. Upstream holds dac_data/dac_valid until the handshake.
- ovf_cnt/udf_cnt clear only on reset.

Optional Feature:
- Macro: ADC_TWOS_COMP_EN.
- Defined: the MSB of adin_data is inverted before the FIFO push, converting offset-binary to two's complement. In mode 00 only, the MSB of dac_data is inverted before it drives daout_data. Modes 01/10/11 are unchanged.
- Undefined: all data passes as raw offset-binary.

Test Plan:
- Reset/clock, CLK_DIV=4: release rst_n → adclk pattern 1,1,0,0 repeating; daout_data=0x80; smp_valid=0; counters=0.
- Capture, smp_ready=1, adin_data=0x3C held: smp_valid pulses one cycle after each tick with smp_data=0x3C; fifo_level returns to 0; ovf_cnt=0.
- Overflow, FIFO_DEPTH=8, smp_ready=0, 10 ticks: fifo_level=8 and ovf_cnt=2. Then 1 pop coinciding with a tick → fifo_level stays 8, ovf_cnt=2.
- DAC stream, mode=00: dac_valid=1 with dac_data=0xA5 → dac_ready high only on tick; daout_data=0xA5 from the cycle after tick. dac_valid=0 for 3 ticks → daout_data holds 0xA5, udf_cnt=3.
- Modes: adin_data=0x12 with mode 01/10/11 → daout_data 0x12/0xED/0x80 after next tick. A mode change mid-period does not alter daout_data before the tick.
- ADC_TWOS_COMP_EN defined: adin_data=0x80 → smp_data=0x00. mode 00 with dac_data=0x00 → daout_data=0x80.

Source files
------------

// File: rtl/adc_dac_stream_bridge.sv
// adc_dac_stream_bridge: converter clock generation, ADC capture FIFO with a
// valid/ready output stream, and a DAC driver with four selectable sources.
// Optional build macro ADC_TWOS_COMP_EN: flip the ADC sample MSB before it is
// queued (offset-binary -> two's complement) and flip the upstream DAC sample
// MSB in stream mode. Without the macro all data passes as raw offset-binary.
module adc_dac_stream_bridge #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          global_clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             adin_data,
  output logic                          adclk,
  output logic                          daclk,
  output logic [DATA_W-1:0]             daout_data,
  input  logic [1:0]                    mode,
  output logic [DATA_W-1:0]             smp_data,
  output logic                          smp_valid,
  input  logic                          smp_ready,
  input  logic [DATA_W-1:0]             dac_data,
  input  logic                          dac_valid,
  output logic                          dac_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    ovf_cnt,
  output logic [7:0]                    udf_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0]     DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]     DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [LW-1:0]     FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [1:0] MODE_STREAM = 2'b00;
  localparam logic [1:0] MODE_LOOP   = 2'b01;
  localparam logic [1:0] MODE_INV    = 2'b10;
  localparam logic [1:0] MODE_MID    = 2'b11;

  // ---------------------------------------------------------------------------
  // Converter clock divider
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          tick;

  // tick marks the last cycle of a sample period, one cycle before adclk rises
  assign tick    = (div_cnt == DIV_LAST);
  assign div_nxt = tick ? '0 : div_cnt + 1'b1;

  // adclk is computed from the next count so it stays aligned with div_cnt
  always_ff @(posedge global_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      adclk   <= 1'b1;
    end else begin
      div_cnt <= div_nxt;
      adclk   <= (div_nxt < DIV_HALF);
    end
  end

  assign daclk = adclk;

  // ---------------------------------------------------------------------------
  // ADC capture FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     count;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [DATA_W-1:0] adc_word;

`ifdef ADC_TWOS_COMP_EN
  assign adc_word = adin_data ^ MIDSCALE;
`else
  assign adc_word = adin_data;
`endif

  assign full = (count == FULL_LVL);
  assign pop  = smp_valid && smp_ready;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push = tick && (!full || pop);
  assign drop = tick && full && !pop;

  // storage carries no reset; occupancy alone decides what is visible
  always_ff @(posedge global_clk) begin
    if (push) mem[wr_ptr] <= adc_word;
  end

  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge global_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // dropped-sample counter, sticks at 255
  always_ff @(posedge global_clk or negedge rst_n) begin
    if (!rst_n)                        ovf_cnt <= '0;
    else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end

  assign smp_valid  = (count != '0);
  assign smp_data   = mem[rd_ptr];
  assign fifo_level = count;

  // ---------------------------------------------------------------------------
  // DAC driver
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] stream_word;

`ifdef ADC_TWOS_COMP_EN
  assign stream_word = dac_data ^ MIDSCALE;
`else
  assign stream_word = dac_data;
`endif

  // upstream is only consumed on a tick in stream mode
  assign dac_ready = tick && (mode == MODE_STREAM);

  // daout changes only on tick so it is settled before the next daclk rise
  always_ff @(posedge global_clk or negedge rst_n) begin
    if (!rst_n) begin
      daout_data <= MIDSCALE;
      udf_cnt    <= '0;
    end else if (tick) begin
      case (mode)
        MODE_STREAM: begin
          if (dac_valid)              daout_data <= stream_word;
          else if (udf_cnt != 8'hFF)  udf_cnt    <= udf_cnt + 8'd1;
        end
        MODE_LOOP: daout_data <= adin_data;
        MODE_INV:  daout_data <= ~adin_data;
        MODE_MID:  daout_data <= MIDSCALE;
        default:   daout_data <= MIDSCALE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_dac_stream_bridge.sv
// Bench for adc_dac_stream_bridge: a queue-based behavioural model is checked
// against the DUT every cycle, plus directed literal checks.
module tb_adc_dac_stream_bridge;

  localparam int DATA_W     = 8;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam logic [DATA_W-1:0] MID = 8'h80;

  logic                        clk;
  logic                        rst_n;
  logic [DATA_W-1:0]           adin_data;
  logic                        adclk, daclk;
  logic [DATA_W-1:0]           daout_data;
  logic [1:0]                  mode;
  logic [DATA_W-1:0]           smp_data;
  logic                        smp_valid;
  logic                        smp_ready;
  logic [DATA_W-1:0]           dac_data;
  logic                        dac_valid;
  logic                        dac_ready;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [7:0]                  ovf_cnt, udf_cnt;

  adc_dac_stream_bridge #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .global_clk(clk), .rst_n(rst_n), .adin_data(adin_data), .adclk(adclk), .daclk(daclk),
    .daout_data(daout_data), .mode(mode), .smp_data(smp_data), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
    .fifo_level(fifo_level), .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] conv(input logic [DATA_W-1:0] x);
`ifdef ADC_TWOS_COMP_EN
    return x ^ MID;
`else
    return x;
`endif
  endfunction

  // Model: sample phase within the period, queue of captured samples, counters
  int                m_phase;
  logic [DATA_W-1:0] m_q[$];
  int                m_ovf, m_udf;
  logic [DATA_W-1:0] m_dac;
  bit                m_tk, m_pp;
  int                m_sz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_q.delete(); m_ovf = 0; m_udf = 0; m_dac = MID;
    end else begin
      m_tk = (m_phase == CLK_DIV - 1);
      m_sz = m_q.size();
      m_pp = (m_sz > 0) && smp_ready;
      if (m_pp) void'(m_q.pop_front());
      if (m_tk) begin
        if (m_sz < FIFO_DEPTH || m_pp) m_q.push_back(conv(adin_data));
        else if (m_ovf < 255) m_ovf++;
        case (mode)
          2'd0: if (dac_valid) m_dac = conv(dac_data); else if (m_udf < 255) m_udf++;
          2'd1: m_dac = adin_data;
          2'd2: m_dac = ~adin_data;
          default: m_dac = MID;
        endcase
      end
      m_phase = (m_phase + 1) % CLK_DIV;
    end
  end

  // Every-cycle comparison, sampled after outputs have settled
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("adclk",      adclk,      (m_phase < CLK_DIV / 2));
      chk("daclk",      daclk,      (m_phase < CLK_DIV / 2));
      chk("daout_data", daout_data, m_dac);
      chk("smp_valid",  smp_valid,  (m_q.size() > 0));
      if (m_q.size() > 0) chk("smp_data", smp_data, m_q[0]);
      chk("fifo_level", fifo_level, m_q.size());
      chk("ovf_cnt",    ovf_cnt,    m_ovf);
      chk("udf_cnt",    udf_cnt,    m_udf);
      chk("dac_ready",  dac_ready,  (m_phase == CLK_DIV - 1) && (mode == 2'd0));
    end
  end

  // Stop at the negedge right before a tick edge
  task automatic to_tick;
    while (m_phase != CLK_DIV - 1) @(negedge clk);
  endtask

  // Stop at the negedge right after a tick edge
  task automatic after_tick;
    to_tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input logic [DATA_W-1:0] exp);
    int g;
    g = 0;
    while (!smp_valid && g < 3 * CLK_DIV) begin @(negedge clk); g++; end
    if (smp_valid) chk(name, smp_data, exp);
    else           chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] pat;

  initial begin
    rst_n = 1'b1; adin_data = '0; mode = 2'd3; smp_ready = 1'b1;
    dac_data = '0; dac_valid = 1'b0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_adclk", adclk, 1);
    chk("rst_daout", daout_data, 8'h80);
    chk("rst_valid", smp_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf",   ovf_cnt, 0);
    chk("rst_udf",   udf_cnt, 0);
    chk("rst_ready", dac_ready, 0);

    // adclk after release: 1,0,0,1,1,0,0,1 (counts 1,2,3,0,...)
    rst_n = 1'b1;
    pat = 8'b1001_1001;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #3;
      chk("adclk_pattern", adclk, pat[7-k]);
    end

    // capture with consumer always ready
    @(negedge clk);
    adin_data = 8'h3C;
    after_tick();
    wait_valid("capture_data", conv(8'h3C));
    after_tick();
    chk("capture_data2", smp_data, conv(8'h3C));
    to_tick();
    chk("capture_level", fifo_level, 0);
    chk("capture_ovf",   ovf_cnt, 0);

    // mid-operation reset, then overflow with no consumer
    @(negedge clk);
    rst_n = 1'b0; smp_ready = 1'b0;
    @(negedge clk);
    chk("midrst_level", fifo_level, 0);
    rst_n = 1'b1;
    repeat (10) after_tick();
    chk("ovf_level", fifo_level, 8);
    chk("ovf_count", ovf_cnt, 2);
    to_tick();
    smp_ready = 1'b1;
    @(negedge clk);
    smp_ready = 1'b0;
    chk("ovf_pop_level", fifo_level, 8);
    chk("ovf_pop_count", ovf_cnt, 2);

    // DAC stream mode
    smp_ready = 1'b1;
    mode = 2'd0; dac_valid = 1'b1; dac_data = 8'hA5;
    to_tick();
    chk("stream_ready_tick", dac_ready, 1);
    @(negedge clk);
    chk("stream_ready_off", dac_ready, 0);
    chk("stream_daout", daout_data, conv(8'hA5));
    dac_valid = 1'b0;
    repeat (3) after_tick();
    chk("stream_hold", daout_data, conv(8'hA5));
    chk("stream_udf",  udf_cnt, 3);

    // loopback / inverted / midscale
    adin_data = 8'h12;
    mode = 2'd1; after_tick(); chk("mode_loop", daout_data, 8'h12);
    mode = 2'd2; after_tick(); chk("mode_inv",  daout_data, 8'hED);
    mode = 2'd3; after_tick(); chk("mode_mid",  daout_data, 8'h80);
    mode = 2'd1; @(negedge clk); chk("mode_mid_period1", daout_data, 8'h80);
    mode = 2'd2; @(negedge clk); chk("mode_mid_period2", daout_data, 8'h80);
    after_tick(); chk("mode_change_tick", daout_data, 8'hED);

`ifdef ADC_TWOS_COMP_EN
    mode = 2'd3; adin_data = 8'h80;
    after_tick();
    chk("tc_smp", smp_data, 8'h00);
    mode = 2'd0; dac_data = 8'h00; dac_valid = 1'b1;
    after_tick();
    chk("tc_dac", daout_data, 8'h80);
`endif

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
